// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared state encoding and stream framing constants for the boot-time
// program loader (imem_loader) and its byte packer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

  // Loader FSM states. CHK and ERROR are only reachable when the
  // checksum option is compiled in.
  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // Header is a 16-bit little-endian word count.
  localparam int HDR_BYTES  = 2;
  // Payload bytes per memory word.
  localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Gathers four stream bytes into one little-endian 32-bit word. The first
// byte of each group lands in word[7:0]. word_valid pulses (combinationally)
// together with the fourth byte, and word is the completed value then.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module byte_packer (
  input  logic        clock,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [31:0] shift_reg;

  // New bytes enter at the top so the oldest byte ends up in [7:0].
  assign word       = {in_byte, shift_reg[31:8]};
  assign word_valid = in_valid & (byte_idx == 2'd3);

  // Byte index and shift register; clear discards any partial word.
  always_ff @(posedge clock) begin
    if (clear) begin
      byte_idx  <= 2'd0;
      shift_reg <= 32'd0;
    end else if (in_valid) begin
      byte_idx  <= byte_idx + 2'd1;
      shift_reg <= word;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader. Takes a byte stream (2-byte word count N, then
// 4*N little-endian payload bytes) over a valid/ready link, writes it into
// memory as 32-bit words starting at BASE_ADDR, and holds the core in reset
// until the final write has completed.
// Optional feature macro: LOADER_CHECKSUM_EN -- a trailing XOR checksum
// byte is verified; a mismatch parks the loader in ERROR.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int BASE_ADDR    = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    mem_wEn,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [31:0]             mem_write_data,
  output logic                    core_reset,
  output logic                    done,
  output logic                    error
);

  localparam logic [ADDRESS_BITS-1:0] BASE     = ADDRESS_BITS'(BASE_ADDR);
  localparam logic [ADDRESS_BITS-1:0] ADDR_INC = ADDRESS_BITS'(WORD_BYTES);

  state_t                  state;
  logic [7:0]              n_lo;
  logic [15:0]             n_words;
  logic [15:0]             word_cnt;
  logic [ADDRESS_BITS-1:0] next_addr;
  logic                    take;
  logic                    packer_valid;
  logic                    word_valid;
  logic [31:0]             word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              xor_acc;
`endif

  assign rx_ready = (state == HDR_LO) | (state == HDR_HI) |
                    (state == DATA)   | (state == CHK);
  assign take     = rx_valid & rx_ready;
  assign done     = (state == DONE) & ~core_reset;

`ifdef LOADER_CHECKSUM_EN
  assign error = (state == ERROR);
`else
  assign error = 1'b0;
`endif

  // Only payload bytes feed the packer; reset throws away a partial word.
  assign packer_valid = take & (state == DATA);

  byte_packer u_packer (
    .clock      (clock),
    .clear      (reset),
    .in_valid   (packer_valid),
    .in_byte    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Loader FSM, counters, address generation and registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= HDR_LO;
      n_lo           <= 8'd0;
      n_words        <= 16'd0;
      word_cnt       <= 16'd0;
      next_addr      <= BASE;
      mem_address    <= BASE;
      mem_write_data <= 32'd0;
      mem_wEn        <= 1'b0;
      core_reset     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      xor_acc        <= 8'd0;
`endif
    end else begin
      mem_wEn <= 1'b0;

      // Release the core only once the last write strobe has retired.
      if ((state == DONE) && !mem_wEn) begin
        core_reset <= 1'b0;
      end

      case (state)
        HDR_LO: begin
          if (take) begin
            n_lo  <= rx_data;
            state <= HDR_HI;
          end
        end

        HDR_HI: begin
          if (take) begin
            n_words  <= {rx_data, n_lo};
            word_cnt <= 16'd0;
            if ({rx_data, n_lo} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
`endif
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
`ifdef LOADER_CHECKSUM_EN
          if (take) begin
            xor_acc <= xor_acc ^ rx_data;
          end
`endif
          if (word_valid) begin
            mem_wEn        <= 1'b1;
            mem_address    <= next_addr;
            mem_write_data <= word;
            next_addr      <= next_addr + ADDR_INC;
            word_cnt       <= word_cnt + 16'd1;
            // Compare against N-1 so the full 16-bit range of N works.
            if (word_cnt == (n_words - 16'd1)) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (take) begin
            state <= (rx_data == xor_acc) ? DONE : ERROR;
          end
        end
`endif

        default: begin
          // DONE and ERROR hold until reset.
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Scoreboarded testbench for imem_loader: expected writes are queued as
// stimulus is issued and popped by monitors watching each mem_wEn strobe.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        drv_valid;
  logic [7:0]  rx_data;
  logic        sel;

  logic        rx_valid0, rx_ready0, wen0, core_reset0, done0, error0;
  logic [15:0] addr0;
  logic [31:0] wdata0;

  logic        rx_valid1, rx_ready1, wen1, core_reset1, done1, error1;
  logic [3:0]  addr1;
  logic [31:0] wdata1;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  wr_t q0[$];
  wr_t q1[$];
  int  wcyc0[$];
  bit  prev_wen0 = 1'b0;
  bit  prev_wen1 = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  assign rx_valid0 = drv_valid & ~sel;
  assign rx_valid1 = drv_valid & sel;

  imem_loader #(.ADDRESS_BITS(16), .BASE_ADDR(0)) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_valid       (rx_valid0),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready0),
    .mem_wEn        (wen0),
    .mem_address    (addr0),
    .mem_write_data (wdata0),
    .core_reset     (core_reset0),
    .done           (done0),
    .error          (error0)
  );

  imem_loader #(.ADDRESS_BITS(4), .BASE_ADDR(12)) dut_wrap (
    .clock          (clock),
    .reset          (reset),
    .rx_valid       (rx_valid1),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready1),
    .mem_wEn        (wen1),
    .mem_address    (addr1),
    .mem_write_data (wdata1),
    .core_reset     (core_reset1),
    .done           (done1),
    .error          (error1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor for the 16-bit instance: every strobe must match the queue head.
  always @(negedge clock) begin
    if (wen0) begin
      if (prev_wen0) flag("wen0_pulse_width");
      if (q0.size() == 0) begin
        flag("wen0_unexpected_write");
      end else begin
        wr_t e;
        e = q0.pop_front();
        check("wr0_addr", {16'd0, addr0}, {16'd0, e.addr});
        check("wr0_data", wdata0, e.data);
        wcyc0.push_back(cyc);
      end
    end
    prev_wen0 = wen0;
  end

  // Monitor for the wrapping 4-bit-address instance.
  always @(negedge clock) begin
    if (wen1) begin
      if (prev_wen1) flag("wen1_pulse_width");
      if (q1.size() == 0) begin
        flag("wen1_unexpected_write");
      end else begin
        wr_t e;
        e = q1.pop_front();
        check("wr1_addr", {28'd0, addr1}, {16'd0, e.addr});
        check("wr1_data", wdata1, e.data);
      end
    end
    prev_wen1 = wen1;
  end

  // Offer one byte and hold it until the selected loader accepts it.
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int  k;
    bit  ok;
    k = 0;
    ok = 1'b0;
    rx_data   = b;
    drv_valid = 1'b1;
    while (!ok && k < 20) begin
      @(negedge clock);
      ok = sel ? rx_ready1 : rx_ready0;
      @(posedge clock);
      #1;
      k++;
    end
    if (!ok) flag("handshake_timeout");
    drv_valid = 1'b0;
    rx_data   = 8'h5A;
    if (toggle) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_seq(input logic [7:0] bytes[], input bit toggle);
    foreach (bytes[i]) send_byte(bytes[i], toggle);
  endtask

  // Checksum trailer is only part of the stream when the option is built.
  task automatic send_tail(input logic [7:0] chk, input bit toggle);
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk, toggle);
`endif
  endtask

  task automatic wait_done(input string name);
    int k;
    logic d;
    k = 0;
    d = 1'b0;
    while (!d && k < 30) begin
      @(negedge clock);
      d = sel ? done1 : done0;
      k++;
    end
    check(name, {31'd0, d}, 32'd1);
  endtask

  task automatic do_reset();
    drv_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] s_a[];
    logic [7:0] s_n0[];
    logic [7:0] s_part[];
    logic [7:0] s_one[];
    logic [7:0] s_chk[];
    s_a    = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    s_n0   = '{8'h00, 8'h00};
    s_part = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    s_one  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    s_chk  = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};

    sel = 1'b0;
    drv_valid = 1'b0;
    rx_data = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset values.
    check("rst_rx_ready",   {31'd0, rx_ready0},   32'd1);
    check("rst_mem_wEn",    {31'd0, wen0},        32'd0);
    check("rst_mem_addr",   {16'd0, addr0},       32'd0);
    check("rst_mem_data",   wdata0,               32'd0);
    check("rst_core_reset", {31'd0, core_reset0}, 32'd1);
    check("rst_done",       {31'd0, done0},       32'd0);
    check("rst_error",      {31'd0, error0},      32'd0);
    check("rst_wrap_addr",  {28'd0, addr1},       32'd12);

    // N=2, back-to-back bytes.
    q0.push_back('{16'h0000, 32'h00000013});
    q0.push_back('{16'h0004, 32'h00100093});
    wcyc0.delete();
    send_seq(s_a, 1'b0);
`ifndef LOADER_CHECKSUM_EN
    check("a_last_wen",        {31'd0, wen0},        32'd1);
    check("a_core_reset_held", {31'd0, core_reset0}, 32'd1);
    @(posedge clock); #1;
    check("a_wen_dropped",     {31'd0, wen0},        32'd0);
    check("a_core_reset_wait", {31'd0, core_reset0}, 32'd1);
    @(posedge clock); #1;
    check("a_core_reset_rel",  {31'd0, core_reset0}, 32'd0);
    check("a_done",            {31'd0, done0},       32'd1);
`else
    send_tail(8'h90, 1'b0);
    wait_done("a_done");
`endif
    check("a_rx_ready_low", {31'd0, rx_ready0}, 32'd0);
    check("a_queue_empty",  q0.size(), 32'd0);
    check("a_write_spacing", (wcyc0.size() == 2) ? (wcyc0[1] - wcyc0[0]) : -1, 32'd4);

    // Same stream with rx_valid toggling every cycle.
    do_reset();
    q0.push_back('{16'h0000, 32'h00000013});
    q0.push_back('{16'h0004, 32'h00100093});
    wcyc0.delete();
    send_seq(s_a, 1'b1);
    send_tail(8'h90, 1'b1);
    wait_done("b_done");
    check("b_queue_empty",   q0.size(), 32'd0);
    check("b_write_spacing", (wcyc0.size() == 2) ? (wcyc0[1] - wcyc0[0]) : -1, 32'd8);

    // N=0: no writes, straight to done.
    do_reset();
    send_seq(s_n0, 1'b0);
`ifndef LOADER_CHECKSUM_EN
    check("n0_done_early", {31'd0, done0}, 32'd0);
    @(posedge clock); #1;
    check("n0_done", {31'd0, done0}, 32'd1);
`else
    send_tail(8'h00, 1'b0);
    wait_done("n0_done");
`endif
    check("n0_rx_ready_low", {31'd0, rx_ready0}, 32'd0);
    repeat (4) @(posedge clock);
    #1;
    check("n0_no_writes", q0.size(), 32'd0);

    // Reset mid-word, then a fresh N=1 image.
    do_reset();
    send_seq(s_part, 1'b0);
    do_reset();
    check("mid_rx_ready",   {31'd0, rx_ready0},   32'd1);
    check("mid_wen",        {31'd0, wen0},        32'd0);
    check("mid_core_reset", {31'd0, core_reset0}, 32'd1);
    check("mid_done",       {31'd0, done0},       32'd0);
    q0.push_back('{16'h0000, 32'hDEADBEEF});
    send_seq(s_one, 1'b0);
    send_tail(8'h22, 1'b0);
    wait_done("mid_done_final");
    check("mid_queue_empty", q0.size(), 32'd0);

    // 4-bit address space starting at 12: second word wraps to 0.
    do_reset();
    sel = 1'b1;
    q1.push_back('{16'h000C, 32'h00000013});
    q1.push_back('{16'h0000, 32'h00100093});
    send_seq(s_a, 1'b0);
    send_tail(8'h90, 1'b0);
    wait_done("wrap_done");
    check("wrap_queue_empty", q1.size(), 32'd0);
    sel = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    // Good checksum.
    do_reset();
    q0.push_back('{16'h0000, 32'h04030201});
    send_seq(s_chk, 1'b0);
    send_byte(8'h04, 1'b0);
    wait_done("chk_good_done");
    check("chk_good_error", {31'd0, error0}, 32'd0);

    // Bad checksum.
    do_reset();
    q0.push_back('{16'h0000, 32'h04030201});
    send_seq(s_chk, 1'b0);
    send_byte(8'h05, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("chk_bad_error",      {31'd0, error0},      32'd1);
    check("chk_bad_core_reset", {31'd0, core_reset0}, 32'd1);
    check("chk_bad_rx_ready",   {31'd0, rx_ready0},   32'd0);
    check("chk_bad_done",       {31'd0, done0},       32'd0);
    check("chk_queue_empty",    q0.size(), 32'd0);
`endif

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
